// File: rtl/uv_bru.sv
// Branch resolution unit: resolves JAL/JALR/BRANCH targets in EX, flushes and redirects the IFU on mispredict.
// Optional perf counters (br_cnt/mis_cnt) are built only when UV_BRU_PERF_EN is defined.
module uv_bru #(
  parameter int ALEN = 32,
  parameter int XLEN = 32
`ifdef UV_BRU_PERF_EN
  ,
  parameter int PCNTW = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex2br_vld,
  output logic            br2ex_rdy,
  input  logic [1:0]      ex2br_op,
  input  logic [2:0]      ex2br_funct3,
  input  logic [ALEN-1:0] ex2br_pc,
  input  logic [XLEN-1:0] ex2br_rs1,
  input  logic [XLEN-1:0] ex2br_rs2,
  input  logic [ALEN-1:0] ex2br_imm,
  input  logic [ALEN-1:0] ex2br_pred_pc,
  output logic [ALEN-1:0] br2ex_link,
  output logic            br2ex_misalign,
  output logic            br2pl_flush,
`ifdef UV_BRU_PERF_EN
  output logic [PCNTW-1:0] br_cnt,
  output logic [PCNTW-1:0] mis_cnt,
`endif
  output logic            br2if_redir_vld,
  output logic [ALEN-1:0] br2if_redir_pc,
  input  logic            if2br_redir_rdy
);

  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_JALR   = 2'b01;
  localparam logic [1:0] OP_JAL    = 2'b11;

  typedef enum logic {IDLE, REDIR} state_t;
  state_t state;

  logic            accept;
  logic            is_bjp;
  logic            cond;
  logic            taken;
  logic [ALEN-1:0] act_pc;
  logic            mispred;
  logic            misalign;

  // Handshakes: a transfer happens on a clock edge where vld and rdy are both high.
  // EX waits on br2ex_rdy; the redirect holds vld and pc stable until the IFU raises rdy.
  assign br2ex_rdy  = (state == IDLE);
  assign accept     = ex2br_vld & br2ex_rdy;
  assign is_bjp     = (ex2br_op != 2'b10);
  assign br2ex_link = ex2br_pc + ALEN'(4);

  always_comb begin
    cond = 1'b0;
    case (ex2br_funct3)
      3'b000:  cond = (ex2br_rs1 == ex2br_rs2);
      3'b001:  cond = (ex2br_rs1 != ex2br_rs2);
      3'b100:  cond = ($signed(ex2br_rs1) <  $signed(ex2br_rs2));
      3'b101:  cond = ($signed(ex2br_rs1) >= $signed(ex2br_rs2));
      3'b110:  cond = (ex2br_rs1 <  ex2br_rs2);
      3'b111:  cond = (ex2br_rs1 >= ex2br_rs2);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    taken  = 1'b0;
    act_pc = ex2br_pc + ALEN'(4);
    case (ex2br_op)
      OP_JAL: begin
        taken  = 1'b1;
        act_pc = ex2br_pc + ex2br_imm;
      end
      OP_JALR: begin
        taken  = 1'b1;
        act_pc = (ALEN'(ex2br_rs1) + ex2br_imm) & ~ALEN'(1);
      end
      OP_BRANCH: begin
        taken  = cond;
        act_pc = cond ? (ex2br_pc + ex2br_imm) : (ex2br_pc + ALEN'(4));
      end
      default: begin
        taken  = 1'b0;
        act_pc = ex2br_pc + ALEN'(4);
      end
    endcase
  end

  // A halfword-aligned target is reported instead of redirected to.
  assign mispred  = accept & is_bjp & (act_pc != ex2br_pred_pc) & ~act_pc[1];
  assign misalign = accept & taken & act_pc[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      br2if_redir_vld <= 1'b0;
      br2if_redir_pc  <= '0;
      br2pl_flush     <= 1'b0;
      br2ex_misalign  <= 1'b0;
    end else begin
      br2pl_flush    <= 1'b0;
      br2ex_misalign <= misalign;
      case (state)
        IDLE: begin
          if (mispred) begin
            state           <= REDIR;
            br2if_redir_vld <= 1'b1;
            br2if_redir_pc  <= act_pc;
            br2pl_flush     <= 1'b1;
          end
        end
        REDIR: begin
          if (if2br_redir_rdy) begin
            state           <= IDLE;
            br2if_redir_vld <= 1'b0;
          end
        end
        default: begin
          state           <= IDLE;
          br2if_redir_vld <= 1'b0;
        end
      endcase
    end
  end

`ifdef UV_BRU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (accept & is_bjp) br_cnt <= br_cnt + PCNTW'(1);
      if (mispred)         mis_cnt <= mis_cnt + PCNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_uv_bru.sv
// Directed bench for uv_bru: reset values, conditions, redirect handshake, wrap, misalign and optional counters.
module tb_uv_bru;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex2br_vld;
  logic        br2ex_rdy;
  logic [1:0]  ex2br_op;
  logic [2:0]  ex2br_funct3;
  logic [31:0] ex2br_pc;
  logic [31:0] ex2br_rs1;
  logic [31:0] ex2br_rs2;
  logic [31:0] ex2br_imm;
  logic [31:0] ex2br_pred_pc;
  logic [31:0] br2ex_link;
  logic        br2ex_misalign;
  logic        br2pl_flush;
  logic        br2if_redir_vld;
  logic [31:0] br2if_redir_pc;
  logic        if2br_redir_rdy;
`ifdef UV_BRU_PERF_EN
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  uv_bru dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex2br_vld       (ex2br_vld),
    .br2ex_rdy       (br2ex_rdy),
    .ex2br_op        (ex2br_op),
    .ex2br_funct3    (ex2br_funct3),
    .ex2br_pc        (ex2br_pc),
    .ex2br_rs1       (ex2br_rs1),
    .ex2br_rs2       (ex2br_rs2),
    .ex2br_imm       (ex2br_imm),
    .ex2br_pred_pc   (ex2br_pred_pc),
    .br2ex_link      (br2ex_link),
    .br2ex_misalign  (br2ex_misalign),
    .br2pl_flush     (br2pl_flush),
`ifdef UV_BRU_PERF_EN
    .br_cnt          (br_cnt),
    .mis_cnt         (mis_cnt),
`endif
    .br2if_redir_vld (br2if_redir_vld),
    .br2if_redir_pc  (br2if_redir_pc),
    .if2br_redir_rdy (if2br_redir_rdy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pred);
    ex2br_vld     = 1'b1;
    ex2br_op      = op;
    ex2br_funct3  = f3;
    ex2br_pc      = pc;
    ex2br_rs1     = rs1;
    ex2br_rs2     = rs2;
    ex2br_imm     = imm;
    ex2br_pred_pc = pred;
  endtask

  task automatic idle_in();
    ex2br_vld = 1'b0;
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_flush"}, 32'(br2pl_flush), 32'd0);
    chk({tag, "_redir_vld"}, 32'(br2if_redir_vld), 32'd0);
    chk({tag, "_rdy"}, 32'(br2ex_rdy), 32'd1);
  endtask

  initial begin
    rst_n           = 1'b0;
    if2br_redir_rdy = 1'b0;
    present(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    idle_in();
    tick();
    tick();
    chk("rst_redir_vld", 32'(br2if_redir_vld), 32'd0);
    chk("rst_redir_pc", br2if_redir_pc, 32'd0);
    chk("rst_flush", 32'(br2pl_flush), 32'd0);
    chk("rst_misalign", 32'(br2ex_misalign), 32'd0);
    chk("rst_rdy", 32'(br2ex_rdy), 32'd1);
`ifdef UV_BRU_PERF_EN
    chk("rst_br_cnt", br_cnt, 32'd0);
    chk("rst_mis_cnt", mis_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // BEQ taken, correctly predicted
    present(2'b00, 3'b000, 32'h100, 32'd5, 32'd5, 32'hFFFF_FFF0, 32'hF0);
    #1 chk("beq_link", br2ex_link, 32'h104);
    tick();
    idle_in();
    quiet("beq");

    // BNE not taken, predicted taken; IFU stalls 5 cycles
    present(2'b00, 3'b001, 32'h200, 32'd7, 32'd7, 32'h20, 32'h220);
    tick();
    idle_in();
    chk("bne_flush", 32'(br2pl_flush), 32'd1);
    chk("bne_redir_vld", 32'(br2if_redir_vld), 32'd1);
    chk("bne_redir_pc", br2if_redir_pc, 32'h204);
    chk("bne_rdy", 32'(br2ex_rdy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bne_hold_flush", 32'(br2pl_flush), 32'd0);
      chk("bne_hold_vld", 32'(br2if_redir_vld), 32'd1);
      chk("bne_hold_pc", br2if_redir_pc, 32'h204);
      chk("bne_hold_rdy", 32'(br2ex_rdy), 32'd0);
    end
    if2br_redir_rdy = 1'b1;
    tick();
    if2br_redir_rdy = 1'b0;
    quiet("bne_done");

    // JALR mispredict, then a mispredicting BEQ stalls behind it
    present(2'b01, 3'b000, 32'h400, 32'h1001, 32'h0, 32'h7, 32'h1004);
    #1 chk("jalr_link", br2ex_link, 32'h404);
    tick();
    chk("jalr_flush", 32'(br2pl_flush), 32'd1);
    chk("jalr_redir_pc", br2if_redir_pc, 32'h1008);
    present(2'b00, 3'b000, 32'h500, 32'd3, 32'd3, 32'h40, 32'h504);
    tick();
    tick();
    chk("stall_flush", 32'(br2pl_flush), 32'd0);
    chk("stall_redir_pc", br2if_redir_pc, 32'h1008);
    chk("stall_rdy", 32'(br2ex_rdy), 32'd0);
    if2br_redir_rdy = 1'b1;
    tick();
    if2br_redir_rdy = 1'b0;
    chk("reidle_rdy", 32'(br2ex_rdy), 32'd1);
    chk("reidle_vld", 32'(br2if_redir_vld), 32'd0);
    chk("reidle_flush", 32'(br2pl_flush), 32'd0);
    tick();
    idle_in();
    chk("b2b_flush", 32'(br2pl_flush), 32'd1);
    chk("b2b_redir_pc", br2if_redir_pc, 32'h540);
    if2br_redir_rdy = 1'b1;
    tick();
    if2br_redir_rdy = 1'b0;

    // BLT signed taken (correct), BLTU unsigned not taken (mispredict)
    present(2'b00, 3'b100, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h308);
    tick();
    idle_in();
    quiet("blt");
    present(2'b00, 3'b110, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h308);
    tick();
    idle_in();
    chk("bltu_flush", 32'(br2pl_flush), 32'd1);
    chk("bltu_redir_pc", br2if_redir_pc, 32'h304);
    if2br_redir_rdy = 1'b1;
    tick();
    if2br_redir_rdy = 1'b0;

    // BGEU taken with unsigned operands, correctly predicted
    present(2'b00, 3'b111, 32'h700, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h710);
    tick();
    idle_in();
    quiet("bgeu");

    // JAL wraps past the top of the address space
    present(2'b11, 3'b000, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 32'h8);
    #1 chk("jal_link_wrap", br2ex_link, 32'h0);
    tick();
    idle_in();
    chk("jal_flush", 32'(br2pl_flush), 32'd1);
    chk("jal_redir_pc", br2if_redir_pc, 32'h4);
    if2br_redir_rdy = 1'b1;
    tick();
    if2br_redir_rdy = 1'b0;

    // JALR to 0x1002: misalign pulse only
    present(2'b01, 3'b000, 32'h800, 32'h1000, 32'h0, 32'h2, 32'h0);
    tick();
    idle_in();
    chk("mis_pulse", 32'(br2ex_misalign), 32'd1);
    quiet("mis");
    tick();
    chk("mis_pulse_end", 32'(br2ex_misalign), 32'd0);

    // reserved op is a no-op even with a wrong prediction
    present(2'b10, 3'b000, 32'h900, 32'h0, 32'h0, 32'h8, 32'h0);
    tick();
    idle_in();
    quiet("rsvd");
    chk("rsvd_misalign", 32'(br2ex_misalign), 32'd0);

    // reset while redirect pending
    present(2'b00, 3'b101, 32'h600, 32'd1, 32'd2, 32'h10, 32'h610);
    tick();
    idle_in();
    chk("pre_rst_vld", 32'(br2if_redir_vld), 32'd1);
    chk("pre_rst_pc", br2if_redir_pc, 32'h604);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(br2if_redir_vld), 32'd0);
    chk("mid_rst_pc", br2if_redir_pc, 32'd0);
    chk("mid_rst_rdy", 32'(br2ex_rdy), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef UV_BRU_PERF_EN
    // 10 BJPs, 3 mispredicts, plus one uncounted reserved op
    if2br_redir_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0 && i > 0)
        present(2'b11, 3'b000, 32'h1000, 32'h0, 32'h0, 32'h40, 32'h1004);
      else
        present(2'b00, 3'b000, 32'h1000, 32'd1, 32'd1, 32'h40, 32'h1040);
      tick();
      idle_in();
      tick();
    end
    present(2'b10, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    idle_in();
    tick();
    chk("perf_br_cnt", br_cnt, 32'd10);
    chk("perf_mis_cnt", mis_cnt, 32'd3);
    if2br_redir_rdy = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
